ifid_queue: RTL and testbench

IFID_QUEUE -- requirements
Module: ifid_queue

---
 rtl/ifid_queue.sv | 85 ++++++++
 tb/tb_ifid_queue.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ifid_queue.sv
// Two-entry IF/ID decoupling queue. Fetch pushes {instr, pc_curr, pc_next}.
// Decode sees the head entry combinationally, so an entry pushed into an
// empty queue is visible right after the edge that wrote it.
// HALT blocks further pushes until a flush. Flush discards everything.
module ifid_queue #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_curr_in,
  input  logic [15:0] pc_next_in,
  input  logic        dec_stall,
  input  logic        flush,
  output logic        fetch_stall,
  output logic        valid_out,
  output logic [15:0] instr_out,
  output logic [15:0] pc_curr_out,
  output logic [15:0] pc_next_out,
  output logic [1:0]  count,
  output logic        halt_seen,
  output logic        err
);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_curr;
    logic [15:0] pc_next;
  } entry_t;

  entry_t      mem [2];
  entry_t      head;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  cnt;
  logic        halt_q;
  logic        full, empty, push, pop, is_halt;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign push    = fetch_valid & ~full & ~halt_q & ~flush;
  assign pop     = ~empty & ~dec_stall & ~flush;
  assign is_halt = (instr_in[15:11] == HALT_OPC);

  // Pointer/occupancy/halt state; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      halt_q <= 1'b0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      halt_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (push && is_halt) halt_q <= 1'b1;
    end
  end

  // Entry storage; stale data is harmless because count gates the outputs.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: instr_in, pc_curr: pc_curr_in, pc_next: pc_next_in};
  end

  assign head        = mem[rd_ptr];
  assign valid_out   = ~empty;
  assign instr_out   = empty ? NOP_INSTR : head.instr;
  assign pc_curr_out = empty ? 16'h0000  : head.pc_curr;
  assign pc_next_out = empty ? 16'h0000  : head.pc_next;
  assign count       = cnt;
  assign halt_seen   = halt_q;
  assign fetch_stall = full | halt_q;
  assign err         = fetch_valid & full & ~halt_q & ~flush;

endmodule

// File: tb/tb_ifid_queue.sv
// Directed vector bench for ifid_queue.
module tb_ifid_queue;

  logic        clk, rst, fetch_valid, dec_stall, flush;
  logic [15:0] instr_in, pc_curr_in, pc_next_in;
  logic        fetch_stall, valid_out, halt_seen, err;
  logic [15:0] instr_out, pc_curr_out, pc_next_out;
  logic [1:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  ifid_queue dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .instr_in(instr_in),
    .pc_curr_in(pc_curr_in), .pc_next_in(pc_next_in), .dec_stall(dec_stall),
    .flush(flush), .fetch_stall(fetch_stall), .valid_out(valid_out),
    .instr_out(instr_out), .pc_curr_out(pc_curr_out), .pc_next_out(pc_next_out),
    .count(count), .halt_seen(halt_seen), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [15:0] instr, pcc, pcn;
    logic        ds, fl;
    logic        e_err;   // combinational, sampled before the edge
    logic        e_vld;
    logic [15:0] e_instr, e_pcc, e_pcn;
    logic [1:0]  e_cnt;
    logic        e_halt, e_fst;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [15:0] ins, input logic [15:0] pcc,
                       input logic [15:0] pcn, input logic ds, input logic fl);
    fetch_valid = fv; instr_in = ins; pc_curr_in = pcc; pc_next_in = pcn;
    dec_stall = ds; flush = fl;
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [15:0] ins,
                         input logic [15:0] pcc, input logic [15:0] pcn,
                         input logic [1:0] cnt, input logic hlt, input logic fst);
    chk({tag, ".valid_out"},   {15'd0, valid_out},   {15'd0, vld});
    chk({tag, ".instr_out"},   instr_out,            ins);
    chk({tag, ".pc_curr_out"}, pc_curr_out,          pcc);
    chk({tag, ".pc_next_out"}, pc_next_out,          pcn);
    chk({tag, ".count"},       {14'd0, count},       {14'd0, cnt});
    chk({tag, ".halt_seen"},   {15'd0, halt_seen},   {15'd0, hlt});
    chk({tag, ".fetch_stall"}, {15'd0, fetch_stall}, {15'd0, fst});
  endtask

  task automatic run_vec(input int k);
    @(negedge clk);
    drive(vt[k].fv, vt[k].instr, vt[k].pcc, vt[k].pcn, vt[k].ds, vt[k].fl);
    #1 chk($sformatf("v%0d.err", k), {15'd0, err}, {15'd0, vt[k].e_err});
    @(posedge clk);
    #1 chk_out($sformatf("v%0d", k), vt[k].e_vld, vt[k].e_instr, vt[k].e_pcc,
               vt[k].e_pcn, vt[k].e_cnt, vt[k].e_halt, vt[k].e_fst);
  endtask

  initial begin
    //            fv instr     pcc       pcn       ds fl err vld instr     pcc       pcn       cnt  hlt fst
    vt[0]  = '{1'b1,16'h4123,16'h0000,16'h0002,1'b0,1'b0,1'b0,1'b1,16'h4123,16'h0000,16'h0002,2'd1,1'b0,1'b0};
    vt[1]  = '{1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0800,16'h0000,16'h0000,2'd0,1'b0,1'b0};
    vt[2]  = '{1'b0,16'h0000,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b0,16'h0800,16'h0000,16'h0000,2'd0,1'b0,1'b0};
    vt[3]  = '{1'b1,16'hA001,16'h0010,16'h0012,1'b1,1'b0,1'b0,1'b1,16'hA001,16'h0010,16'h0012,2'd1,1'b0,1'b0};
    vt[4]  = '{1'b1,16'hA002,16'h0012,16'h0014,1'b1,1'b0,1'b0,1'b1,16'hA001,16'h0010,16'h0012,2'd2,1'b0,1'b1};
    vt[5]  = '{1'b1,16'hA003,16'h0014,16'h0016,1'b1,1'b0,1'b1,1'b1,16'hA001,16'h0010,16'h0012,2'd2,1'b0,1'b1};
    vt[6]  = '{1'b1,16'hA003,16'h0014,16'h0016,1'b0,1'b0,1'b1,1'b1,16'hA002,16'h0012,16'h0014,2'd1,1'b0,1'b0};
    vt[7]  = '{1'b1,16'hA003,16'h0014,16'h0016,1'b0,1'b0,1'b0,1'b1,16'hA003,16'h0014,16'h0016,2'd1,1'b0,1'b0};
    // after the push/pop streaming loop
    vt[8]  = '{1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0800,16'h0000,16'h0000,2'd0,1'b0,1'b0};
    vt[9]  = '{1'b1,16'h0000,16'h0200,16'h0202,1'b1,1'b0,1'b0,1'b1,16'h0000,16'h0200,16'h0202,2'd1,1'b1,1'b1};
    vt[10] = '{1'b1,16'h5555,16'h0202,16'h0204,1'b1,1'b0,1'b0,1'b1,16'h0000,16'h0200,16'h0202,2'd1,1'b1,1'b1};
    vt[11] = '{1'b1,16'h5555,16'h0202,16'h0204,1'b0,1'b0,1'b0,1'b0,16'h0800,16'h0000,16'h0000,2'd0,1'b1,1'b1};
    vt[12] = '{1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b1,1'b0,1'b0,16'h0800,16'h0000,16'h0000,2'd0,1'b0,1'b0};
    vt[13] = '{1'b1,16'hB001,16'h0300,16'h0302,1'b1,1'b0,1'b0,1'b1,16'hB001,16'h0300,16'h0302,2'd1,1'b0,1'b0};
    vt[14] = '{1'b1,16'hB002,16'h0302,16'h0304,1'b1,1'b0,1'b0,1'b1,16'hB001,16'h0300,16'h0302,2'd2,1'b0,1'b1};
    vt[15] = '{1'b1,16'hB003,16'h0304,16'h0306,1'b0,1'b1,1'b0,1'b0,16'h0800,16'h0000,16'h0000,2'd0,1'b0,1'b0};
    vt[16] = '{1'b1,16'hC001,16'h0400,16'h0402,1'b0,1'b0,1'b0,1'b1,16'hC001,16'h0400,16'h0402,2'd1,1'b0,1'b0};

    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    #3;
    chk("reset.err", {15'd0, err}, 16'd0);
    chk_out("reset", 1'b0, 16'h0800, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 8; k++) run_vec(k);

    // count held at 1 with push and pop every cycle: head follows each new entry
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 16'h1000 + 16'(i), 16'h0100 + 16'(2*i), 16'h0102 + 16'(2*i), 1'b0, 1'b0);
      #1 chk($sformatf("stream%0d.err", i), {15'd0, err}, 16'd0);
      @(posedge clk);
      #1 chk_out($sformatf("stream%0d", i), 1'b1, 16'h1000 + 16'(i),
                 16'h0100 + 16'(2*i), 16'h0102 + 16'(2*i), 2'd1, 1'b0, 1'b0);
    end

    for (int k = 8; k < 17; k++) run_vec(k);

    // fill to 2, then pull reset between edges: outputs clear without a clock
    @(negedge clk);
    drive(1'b1, 16'hC002, 16'h0402, 16'h0404, 1'b1, 1'b0);
    @(posedge clk);
    #1 chk_out("prerst", 1'b1, 16'hC001, 16'h0400, 16'h0402, 2'd2, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("asyncrst.err", {15'd0, err}, 16'd0);
    chk_out("asyncrst", 1'b0, 16'h0800, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 16'hD001, 16'h0500, 16'h0502, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk_out("postrst", 1'b1, 16'hD001, 16'h0500, 16'h0502, 2'd1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
